// File: rtl/digit_score_ctrl.sv
// BCD score counter with ripple-carry add, frame-synchronous shadow copy and beam-to-digit mapping.
// Optional build macro LEADING_ZERO_BLANK_EN hides leading zero digits (the LS digit always shows).
module digit_score_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int X_ORIGIN   = 0,
  parameter int Y_ORIGIN   = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_inc,
  input  logic [3:0] i_inc_amt,
  input  logic       i_clear,
  input  logic       i_frame_start,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_overflow,
  output logic [3:0] o_digit,
  output logic       o_digit_valid,
  output logic [1:0] o_dbg_state
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] digits;
  logic [DW-1:0] shadow;
  logic [3:0]    amt;
  logic          carry;
  logic [2:0]    idx;
  logic          pending;
  logic          overflow_q;
  logic          accept_inc;

  // Handshake: i_inc / i_clear are single-cycle requests honoured only in IDLE;
  // anything arriving while busy is dropped, never queued.
  assign accept_inc = (state == S_IDLE) && i_inc && !i_clear;

  assign o_busy      = (state != S_IDLE);
  assign o_done      = (state == S_DONE);
  assign o_overflow  = overflow_q;
  assign o_dbg_state = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_inc) state_nxt = S_ADD;
      S_ADD:   if (idx == LAST_IDX) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One digit of the ripple add; the addend only enters at digit 0.
  logic [3:0] cur_digit;
  logic [3:0] addend;
  logic [4:0] sum;
  logic [4:0] sum_m10;
  logic [3:0] sum_digit;
  logic       sum_carry;

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) cur_digit = digits[i*4 +: 4];
    end
    addend    = (idx == 3'd0) ? amt : 4'd0;
    sum       = {1'b0, cur_digit} + {1'b0, addend} + {4'd0, carry};
    sum_m10   = sum - 5'd10;
    sum_carry = (sum >= 5'd10);
    sum_digit = sum_carry ? sum_m10[3:0] : sum[3:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      digits     <= '0;
      shadow     <= '0;
      amt        <= 4'd0;
      carry      <= 1'b0;
      idx        <= 3'd0;
      pending    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_frame_start) shadow <= digits;
          if (i_clear) begin
            digits     <= '0;
            overflow_q <= 1'b0;
          end else if (i_inc) begin
            amt   <= (i_inc_amt > 4'd9) ? 4'd9 : i_inc_amt;
            idx   <= 3'd0;
            carry <= 1'b0;
          end
        end
        S_ADD: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 3'(i)) digits[i*4 +: 4] <= sum_digit;
          end
          carry <= sum_carry;
          idx   <= idx + 3'd1;
          if ((idx == LAST_IDX) && sum_carry) overflow_q <= 1'b1;
          if (i_frame_start) pending <= 1'b1;
        end
        S_DONE: begin
          // Digits are final here, so a deferred (or just-arrived) frame copy is safe.
          if (pending || i_frame_start) shadow <= digits;
          pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Beam mapping: pos is the digit index under the beam (MS digit leftmost).
  int   hpos_i;
  int   vpos_i;
  int   pos;
  logic in_field;
  logic blank;
  logic [3:0] sel_digit;

  always_comb begin
    hpos_i    = int'({22'd0, i_hpos});
    vpos_i    = int'({22'd0, i_vpos});
    in_field  = (hpos_i >= X_ORIGIN) && (hpos_i < X_ORIGIN + 16 * NUM_DIGITS) &&
                (vpos_i >= Y_ORIGIN) && (vpos_i < Y_ORIGIN + 16);
    pos       = NUM_DIGITS - 1 - ((hpos_i - X_ORIGIN) >>> 4);
    sel_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (pos == i) sel_digit = shadow[i*4 +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic run_zero;
  always_comb begin
    blank    = 1'b0;
    run_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero = run_zero && (shadow[i*4 +: 4] == 4'd0);
      if ((pos == i) && (i != 0) && run_zero) blank = 1'b1;
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_digit       <= 4'd0;
      o_digit_valid <= 1'b0;
    end else if (in_field && !blank) begin
      o_digit       <= sel_digit;
      o_digit_valid <= 1'b1;
    end else begin
      o_digit       <= 4'd0;
      o_digit_valid <= 1'b0;
    end
  end

endmodule
